// File: rtl/aes_pkg.sv
// Shared constants and the controller state encoding for the AES job arbiter.
package aes_pkg;

  localparam int AES_BLK         = 128;
  localparam int DEFAULT_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/aes_job_arbiter_if.sv
// Request, core and response signals of the AES job arbiter.
// The master view belongs to the arbiter, the slave view to its surroundings.
interface aes_job_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);

  logic [NUM_REQ-1:0]                  i_req_valid;
  logic [NUM_REQ-1:0]                  o_req_ready;
  logic [NUM_REQ*aes_pkg::AES_BLK-1:0] i_req_plain;
  logic [NUM_REQ*aes_pkg::AES_BLK-1:0] i_req_key;

  logic                                o_core_start;
  logic [aes_pkg::AES_BLK-1:0]         o_core_plain;
  logic [aes_pkg::AES_BLK-1:0]         o_core_key;
  logic                                i_core_done;
  logic [aes_pkg::AES_BLK-1:0]         i_core_cipher;

  logic                                o_rsp_valid;
  logic                                i_rsp_ready;
  logic [aes_pkg::AES_BLK-1:0]         o_rsp_cipher;
  logic [ID_W-1:0]                     o_rsp_id;
  logic                                o_rsp_timeout;
  logic                                o_busy;

  modport master (
    input  i_req_valid, i_req_plain, i_req_key, i_core_done, i_core_cipher, i_rsp_ready,
    output o_req_ready, o_core_start, o_core_plain, o_core_key,
           o_rsp_valid, o_rsp_cipher, o_rsp_id, o_rsp_timeout, o_busy
  );

  modport slave (
    output i_req_valid, i_req_plain, i_req_key, i_core_done, i_core_cipher, i_rsp_ready,
    input  o_req_ready, o_core_start, o_core_plain, o_core_key,
           o_rsp_valid, o_rsp_cipher, o_rsp_id, o_rsp_timeout, o_busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index,
// searching upward from ptr with wraparound.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  always_comb begin : scan
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // Walk offsets from far to near so the requester closest to ptr wins.
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one iterative AES-128 core between NUM_REQ requesters: round-robin
// accept, one-cycle launch, guarded/watchdogged wait, buffered response.
module aes_job_arbiter
  import aes_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 16,
  parameter int GUARD   = 2
) (
  input logic               i_clock,
  input logic               i_reset_n,
  aes_job_arbiter_if.master bus
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [AES_BLK-1:0] core_plain_q, core_plain_d;
  logic [AES_BLK-1:0] core_key_q, core_key_d;
  logic [AES_BLK-1:0] rsp_cipher_q, rsp_cipher_d;
  logic               core_start_q, core_start_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               done_ok, limit_hit;
  logic [AES_BLK-1:0] plain_arr [NUM_REQ];
  logic [AES_BLK-1:0] key_arr   [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign plain_arr[gi] = bus.i_req_plain[gi*AES_BLK +: AES_BLK];
      assign key_arr[gi]   = bus.i_req_key[gi*AES_BLK +: AES_BLK];
    end
  endgenerate

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req       (bus.i_req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Saturating watchdog; done is only trusted once the guard window has passed,
  // so a done level left over from the previous job cannot complete this one.
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign done_ok   = bus.i_core_done && (cnt_q >= CNT_W'(GUARD));
  assign limit_hit = (cnt_inc >= CNT_W'(TIMEOUT));

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    rsp_id_d      = rsp_id_q;
    core_plain_d  = core_plain_q;
    core_key_d    = core_key_q;
    rsp_cipher_d  = rsp_cipher_q;
    core_start_d  = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          core_plain_d = plain_arr[grant_idx];
          core_key_d   = key_arr[grant_idx];
          rsp_id_d     = grant_idx;
          rr_ptr_d     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          core_start_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (done_ok) begin
          rsp_cipher_d  = bus.i_core_cipher;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (limit_hit) begin
          rsp_cipher_d  = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      rsp_id_q      <= '0;
      core_plain_q  <= '0;
      core_key_q    <= '0;
      rsp_cipher_q  <= '0;
      core_start_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      rsp_id_q      <= rsp_id_d;
      core_plain_q  <= core_plain_d;
      core_key_q    <= core_key_d;
      rsp_cipher_q  <= rsp_cipher_d;
      core_start_q  <= core_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.o_req_ready   = (state_q == S_IDLE) ? grant : '0;
  assign bus.o_core_start  = core_start_q;
  assign bus.o_core_plain  = core_plain_q;
  assign bus.o_core_key    = core_key_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_cipher  = rsp_cipher_q;
  assign bus.o_rsp_id      = rsp_id_q;
  assign bus.o_rsp_timeout = rsp_timeout_q;
  assign bus.o_busy        = (state_q != S_IDLE);

endmodule

// File: doc/aes_job_arbiter.md
Name: aes_job_arbiter

Overview:
- Sequences the shared iterative AES-128 encryption core between NUM_REQ independent requesters.
- Accepts plaintext/key jobs over per-requester valid/ready channels and selects one by round-robin.
- Launches the core, waits for completion with a timeout watchdog, and returns the ciphertext plus requester ID on one buffered response channel.
- Sits between the bus-side job queues and the AES core; it is the only block that drives the core's start, plaintext and key inputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of the requester ID; must be at least clog2(NUM_REQ).
- TIMEOUT, 1023, maximum number of WAIT cycles before the job is aborted.
- CNT_W, 16, width of the watchdog counter.
- GUARD, 2, number of WAIT cycles during which i_core_done is ignored.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req_valid  in  NUM_REQ  per-requester job valid.
- o_req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- i_req_plain  in  NUM_REQ*128  plaintexts; requester k occupies bits [128k+127:128k].
- i_req_key  in  NUM_REQ*128  keys; same packing as i_req_plain.
- o_core_start  out  1  one-cycle launch pulse to the core.
- o_core_plain  out  128  plaintext to the core; stable from start until the job finishes.
- o_core_key  out  128  key to the core; same stability rule.
- i_core_done  in  1  core finished (level); the cipher is valid while high.
- i_core_cipher  in  128  core result.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  response consumer accept.
- o_rsp_cipher  out  128  ciphertext; all zero on timeout.
- o_rsp_id  out  ID_W  index of the requester that owns the response.
- o_rsp_timeout  out  1  set when the job was aborted by the watchdog.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active low) forces:
  - state=IDLE and rr_ptr=0;
  - o_req_ready=0, o_core_start=0, o_rsp_valid=0, o_rsp_timeout=0, o_busy=0;
  - o_core_plain, o_core_key, o_rsp_cipher and o_rsp_id all zero;
  - wait counter=0.
- Reset asserted mid-job discards the job with no response. The core is assumed to be reset by the same net.
- IDLE:
  - If any i_req_valid is set, grant the first valid index found searching upward from rr_ptr with wraparound.
  - In the same cycle, pulse o_req_ready[g]=1 (combinational from state and valid), latch plain, key and ID from requester g, set rr_ptr=(g+1) mod NUM_REQ, and go to ISSUE.
  - o_req_ready is never asserted outside IDLE.
  - If a requester drops valid before being granted, it is simply not granted; no error is raised.
- ISSUE:
  - Drive o_core_start=1 for exactly one cycle, clear the counter, and go to WAIT.
- WAIT:
  - Increment the counter every cycle.
  - Ignore i_core_done while counter < GUARD, so a stale done from the previous job is not taken.
  - Done seen with counter >= GUARD: capture i_core_cipher into o_rsp_cipher, set timeout=0, go to RESP.
  - Otherwise, when counter reaches TIMEOUT: set o_rsp_cipher=0 and timeout=1, go to RESP.
  - If done and the timeout limit occur in the same cycle, done wins.
- RESP:
  - Hold o_rsp_valid=1 with cipher, ID and timeout stable until i_rsp_ready=1.
  - On that handshake cycle, deassert valid and go to IDLE.
  - A new grant happens no earlier than the cycle after the handshake.
- Latency:
  - Request accept to o_core_start: 1 cycle.
  - i_core_done to o_rsp_valid: 1 cycle.
  - A response accepted in cycle t allows the next accept in cycle t+1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…
- The counter saturates at its maximum value and never wraps.

Decomposition:
- Shared package aes_pkg holds:
  - block width constant AES_BLK=128;
  - state encoding constants S_IDLE, S_ISSUE, S_WAIT, S_RESP (2-bit);
  - default TIMEOUT.
- One sub-module is natural: rr_arbiter (combinational one-hot grant from a request vector and rr_ptr, plus the encoded index), reusable elsewhere in the design.

Test Plan:
- FIPS-197 vector (all fields 128-bit hex): requester 0 sends plain=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c; core model asserts done after 60 cycles with the cipher. Required: o_rsp_cipher=3925841d02dc09fbdc118597196a0b32, id=0, timeout=0, start pulsed exactly once.
- Both requesters continuously valid for 4 jobs, rsp_ready tied high. Required: grant order 0,1,0,1; o_rsp_id sequence 0,1,0,1.
- Core never asserts done, TIMEOUT=1023. Required: o_rsp_valid at WAIT cycle 1023, timeout=1, cipher=0; the arbiter then serves the next request normally.
- Core done held high from the previous job. Required: done is not accepted during the GUARD cycles; the response appears only after the core model drops done and raises it again.
- i_rsp_ready held low for 20 cycles while requester 1 is valid. Required: o_req_ready stays 0 and the response fields stay stable; requester 1 is accepted the cycle after the handshake.
- i_reset_n pulsed low during WAIT. Required: all outputs zero immediately (asynchronously), no response emitted, rr_ptr=0 afterward.
